block_mem_responder: RTL and testbench

Synthesizable backing-memory responder serving the cache's block refill and write-back traffic. Accepts one block-granular request at a time (read = refill, write = dirty eviction) and moves the 64-byte block as fixed-width beats over valid/ready channels. An optional programmable access latency precedes read data. It replaces the behavioural memory array as the memory end of the cache↔memory interface.

---
 rtl/block_mem_pkg.sv | 24 ++
 rtl/block_mem_storage.sv | 32 +++
 rtl/block_mem_responder.sv | 155 +++++++++++++++
 tb/tb_block_mem_responder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_mem_pkg.sv
// block_mem_pkg
// Shared types and sizing helpers for the block memory responder.
//   state_t          : responder FSM states
//   beats_per_block  : number of beats that make up one block
//   idx_width        : bit width needed to index n items (never less than 1)
package block_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

  function automatic int beats_per_block(input int block_bytes, input int beat_bytes);
    return block_bytes / beat_bytes;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_mem_storage.sv
// block_mem_storage
// Beat-wide backing array, DEPTH = blocks * beats, addressed by {block, beat}.
// Ports:
//   clk          : clock, rising edge
//   we           : write enable, commits wdata at waddr on the clock edge
//   waddr, wdata : synchronous write port
//   raddr, rdata : asynchronous read port
// Contents power up as zero and are never cleared by reset.
module block_mem_storage #(
  parameter int DEPTH  = 131072,
  parameter int ADDR_W = 17,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BEAT_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BEAT_W-1:0] rdata
);

  logic [BEAT_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/block_mem_responder.sv
// block_mem_responder
// Memory end of the cache<->memory interface. Serves one block request at a
// time: a read (refill) streams BEATS beats out on rdata after LATENCY idle
// cycles, a write (dirty eviction) takes BEATS beats in on wdata and then
// pulses wack for one cycle.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : request channel, req_write, req_block
//   wdata_valid/wdata_ready       : write beat channel, wdata, wdata_last
//   rdata_valid/rdata_ready       : read beat channel, rdata, rdata_last
//   wack                          : one-cycle pulse when a write-back commits
//   protocol_err                  : sticky, wdata_last seen on the wrong beat
//   rd_count, wr_count            : completed reads / writes (wrap at 2^32)
//   dbg_state                     : current FSM state encoding
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; the producer holds payload stable while
// valid is high and ready is low, and ready may not depend on later cycles.
module block_mem_responder
  import block_mem_pkg::*;
#(
  parameter int MEM_BLOCKS  = 16384,
  parameter int BLOCK_BYTES = 64,
  parameter int BEAT_BYTES  = 8,
  parameter int LATENCY     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [$clog2(MEM_BLOCKS)-1:0] req_block,
  input  logic                          wdata_valid,
  output logic                          wdata_ready,
  input  logic [BEAT_BYTES*8-1:0]       wdata,
  input  logic                          wdata_last,
  output logic                          rdata_valid,
  input  logic                          rdata_ready,
  output logic [BEAT_BYTES*8-1:0]       rdata,
  output logic                          rdata_last,
  output logic                          wack,
  output logic                          protocol_err,
  output logic [31:0]                   rd_count,
  output logic [31:0]                   wr_count,
  output logic [2:0]                    dbg_state
);

  localparam int BEATS  = beats_per_block(BLOCK_BYTES, BEAT_BYTES);
  localparam int ADDR_W = $clog2(MEM_BLOCKS);
  localparam int IDX_W  = idx_width(BEATS);
  localparam int LAT_W  = idx_width(LATENCY + 1);
  localparam int BEAT_W = BEAT_BYTES * 8;

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   block_q;
  logic [IDX_W-1:0]    beat_q;
  logic [LAT_W-1:0]    lat_q;
  logic                mem_we;
  logic [ADDR_W+IDX_W-1:0] mem_addr;

  // Only one transfer is ever in flight, so read and write share one address.
  assign mem_addr = {block_q, beat_q};
  // Reset wins over a beat offered in the same cycle.
  assign mem_we   = (state == ST_WRITE) && wdata_valid && !rst;

  block_mem_storage #(
    .DEPTH  (MEM_BLOCKS * BEATS),
    .ADDR_W (ADDR_W + IDX_W),
    .BEAT_W (BEAT_W)
  ) u_storage (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_addr),
    .wdata (wdata),
    .raddr (mem_addr),
    .rdata (rdata)
  );

  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    wack        = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nx = req_write ? ST_WRITE : ((LATENCY > 0) ? ST_WAIT : ST_READ);
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) state_nx = ST_READ;
      end
      ST_READ: begin
        rdata_valid = 1'b1;
        if (rdata_ready && beat_q == LAST_BEAT) state_nx = ST_IDLE;
      end
      ST_WRITE: begin
        wdata_ready = 1'b1;
        // Beat count alone ends the transfer; wdata_last only feeds the error flag.
        if (wdata_valid && beat_q == LAST_BEAT) state_nx = ST_ACK;
      end
      ST_ACK: begin
        wack     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign rdata_last = rdata_valid && (beat_q == LAST_BEAT);
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      block_q      <= '0;
      beat_q       <= '0;
      lat_q        <= '0;
      protocol_err <= 1'b0;
      rd_count     <= 32'd0;
      wr_count     <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            block_q <= req_block;
            beat_q  <= '0;
            lat_q   <= LAT_LOAD;
          end
        end
        ST_WAIT: lat_q <= lat_q - 1'b1;
        ST_READ: begin
          if (rdata_ready) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) rd_count <= rd_count + 32'd1;
          end
        end
        ST_WRITE: begin
          if (wdata_valid) begin
            beat_q <= beat_q + 1'b1;
            if (wdata_last != (beat_q == LAST_BEAT)) protocol_err <= 1'b1;
          end
        end
        ST_ACK: wr_count <= wr_count + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_mem_responder.sv
// tb_block_mem_responder
// Two responders share the stimulus: dut_a with LATENCY=4, dut_b with
// LATENCY=0. 'sel' picks which one sees req/wdata valids and whose outputs
// are observed. A block-level memory model predicts every read beat; one
// negedge process compares each offered beat against the expected queue.
module tb_block_mem_responder;

  localparam int BEATS = 8;
  localparam int AW    = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, sel;
  logic        req_valid, req_write;
  logic [AW-1:0] req_block;
  logic        wdata_valid, wdata_last, rdata_ready;
  logic [63:0] wdata;

  logic        req_ready_a, wdata_ready_a, rdata_valid_a, rdata_last_a, wack_a, perr_a;
  logic [63:0] rdata_a;
  logic [31:0] rdc_a, wrc_a;
  logic [2:0]  st_a;
  logic        req_ready_b, wdata_ready_b, rdata_valid_b, rdata_last_b, wack_b, perr_b;
  logic [63:0] rdata_b;
  logic [31:0] rdc_b, wrc_b;
  logic [2:0]  st_b;

  logic req_valid_a, req_valid_b, wdata_valid_a, wdata_valid_b;
  assign req_valid_a   = req_valid & ~sel;
  assign req_valid_b   = req_valid & sel;
  assign wdata_valid_a = wdata_valid & ~sel;
  assign wdata_valid_b = wdata_valid & sel;

  logic        cur_req_ready, cur_wdata_ready, cur_rdata_valid, cur_rdata_last, cur_wack, cur_perr;
  logic [63:0] cur_rdata;
  logic [31:0] cur_rdc, cur_wrc;
  assign cur_req_ready   = sel ? req_ready_b   : req_ready_a;
  assign cur_wdata_ready = sel ? wdata_ready_b : wdata_ready_a;
  assign cur_rdata_valid = sel ? rdata_valid_b : rdata_valid_a;
  assign cur_rdata_last  = sel ? rdata_last_b  : rdata_last_a;
  assign cur_wack        = sel ? wack_b        : wack_a;
  assign cur_perr        = sel ? perr_b        : perr_a;
  assign cur_rdata       = sel ? rdata_b       : rdata_a;
  assign cur_rdc         = sel ? rdc_b         : rdc_a;
  assign cur_wrc         = sel ? wrc_b         : wrc_a;

  block_mem_responder #(.LATENCY(4)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write), .req_block(req_block),
    .wdata_valid(wdata_valid_a), .wdata_ready(wdata_ready_a), .wdata(wdata), .wdata_last(wdata_last),
    .rdata_valid(rdata_valid_a), .rdata_ready(rdata_ready), .rdata(rdata_a), .rdata_last(rdata_last_a),
    .wack(wack_a), .protocol_err(perr_a), .rd_count(rdc_a), .wr_count(wrc_a), .dbg_state(st_a)
  );

  block_mem_responder #(.LATENCY(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write), .req_block(req_block),
    .wdata_valid(wdata_valid_b), .wdata_ready(wdata_ready_b), .wdata(wdata), .wdata_last(wdata_last),
    .rdata_valid(rdata_valid_b), .rdata_ready(rdata_ready), .rdata(rdata_b), .rdata_last(rdata_last_b),
    .wack(wack_b), .protocol_err(perr_b), .rd_count(rdc_b), .wr_count(wrc_b), .dbg_state(st_b)
  );

  // ---------------- model and scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [511:0] mm [int];          // key = instance*65536 + block
  logic [64:0]  exp_q[$];          // {last, data} of each beat still to be read
  int           exp_rd[2];
  int           exp_wr[2];
  logic         exp_err[2];
  logic [63:0]  wbuf[8];
  logic [63:0]  got[8];

  function automatic logic [63:0] model_beat(input logic s, input int blk, input int i);
    logic [511:0] b;
    int key;
    key = (s ? 65536 : 0) + blk;
    b = mm.exists(key) ? mm[key] : 512'd0;
    return b[i*64 +: 64];
  endfunction

  task automatic model_write(input logic s, input int blk, input int i, input logic [63:0] d);
    logic [511:0] b;
    int key;
    key = (s ? 65536 : 0) + blk;
    b = mm.exists(key) ? mm[key] : 512'd0;
    b[i*64 +: 64] = d;
    mm[key] = b;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cur_rdata_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rdata_unexpected: got beat %h with none expected", cur_rdata);
      end else begin
        if ({cur_rdata_last, cur_rdata} !== exp_q[0]) begin
          bad++;
          $display("FAIL rdata_beat: got last=%b data=%h expected last=%b data=%h",
                   cur_rdata_last, cur_rdata, exp_q[0][64], exp_q[0][63:0]);
        end
        if (rdata_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_expect();
    exp_rd[0] = 0; exp_rd[1] = 0;
    exp_wr[0] = 0; exp_wr[1] = 0;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; req_valid = 1'b0; wdata_valid = 1'b0; wdata_last = 1'b0; rdata_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    clear_expect();
  endtask

  task automatic send_req(input logic wr, input int blk, output int k);
    int t;
    t = 0;
    while (cur_req_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("req_ready_wait", 64'(cur_req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_block = AW'(blk);
    @(posedge clk); #1;
    k = cyc;
    req_valid = 1'b0;
  endtask

  task automatic do_read(input int blk, input int stall_beat, input int stall_n,
                         output int acc, output int last);
    int lat, done, stalls, k;
    bit seen, hs;
    lat = sel ? 0 : 4;
    done = 0; stalls = 0; seen = 0; last = -1;
    for (int i = 0; i < BEATS; i++) exp_q.push_back({(i == BEATS - 1), model_beat(sel, blk, i)});
    rdata_ready = 1'b1;
    send_req(1'b0, blk, k);
    for (int t = 0; t < 100 && done < BEATS; t++) begin
      hs = 0;
      if (cur_rdata_valid === 1'b1) begin
        if (!seen) begin
          seen = 1;
          check("first_beat_cycle", 64'(cyc - k + 1), 64'(lat + 1));
        end
        if (done == stall_beat && stalls < stall_n) begin
          rdata_ready = 1'b0; stalls++;
        end else begin
          rdata_ready = 1'b1;
        end
        hs = rdata_ready;
        if (hs) got[done] = cur_rdata;
      end
      @(posedge clk); #1;
      if (hs) begin
        done++;
        if (done == BEATS) last = cyc;
      end
    end
    rdata_ready = 1'b0;
    check("read_beats_done", 64'(done), 64'(BEATS));
    check("read_last_cycle", 64'(last - k), 64'(lat + BEATS + stall_n));
    check("req_ready_after_read", 64'(cur_req_ready), 64'd1);
    exp_rd[sel]++;
    check("rd_count", 64'(cur_rdc), 64'(exp_rd[sel]));
    acc = k;
  endtask

  // n_beats < BEATS: reset is raised right after that many beats, with the
  // next beat still offered so it must be dropped.
  task automatic do_write(input int blk, input int last_pos, input int n_beats);
    int k, i, nw, wc;
    bit hs;
    i = 0; nw = 0; wc = -1;
    send_req(1'b1, blk, k);
    wdata_valid = 1'b1;
    for (int t = 0; t < 100 && i < n_beats; t++) begin
      wdata = wbuf[i]; wdata_last = (i == last_pos);
      hs = cur_wdata_ready;
      @(posedge clk); #1;
      if (hs) begin
        model_write(sel, blk, i, wbuf[i]);
        if ((i == last_pos) != (i == BEATS - 1)) exp_err[sel] = 1'b1;
        i++;
      end
    end
    check("write_beats", 64'(i), 64'(n_beats));
    if (n_beats < BEATS) begin
      wdata = wbuf[i]; wdata_last = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; wdata_valid = 1'b0;
      clear_expect();
      check("wack_after_abort", 64'(cur_wack), 64'd0);
      check("req_ready_after_abort", 64'(cur_req_ready), 64'd1);
      check("wr_count_after_abort", 64'(cur_wrc), 64'd0);
      check("perr_after_abort", 64'(cur_perr), 64'd0);
    end else begin
      wdata_valid = 1'b0; wdata_last = 1'b0;
      for (int t = 0; t < 4; t++) begin
        if (cur_wack === 1'b1) begin
          nw++;
          if (wc < 0) wc = cyc + 1;
        end
        @(posedge clk); #1;
      end
      check("wack_pulses", 64'(nw), 64'd1);
      check("wack_cycle", 64'(wc - k), 64'(BEATS + 1));
      exp_wr[sel]++;
      check("wr_count", 64'(cur_wrc), 64'(exp_wr[sel]));
      check("protocol_err", 64'(cur_perr), 64'(exp_err[sel]));
      check("req_ready_after_write", 64'(cur_req_ready), 64'd1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc1, lst1, acc2, lst2;
    sel = 1'b0; rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_block = '0;
    wdata_valid = 1'b0; wdata_last = 1'b0; wdata = '0; rdata_ready = 1'b0;
    clear_expect();
    do_reset(2);

    check("rst_req_ready",   64'(req_ready_a),   64'd1);
    check("rst_wdata_ready", 64'(wdata_ready_a), 64'd0);
    check("rst_rdata_valid", 64'(rdata_valid_a), 64'd0);
    check("rst_rdata_last",  64'(rdata_last_a),  64'd0);
    check("rst_wack",        64'(wack_a),        64'd0);
    check("rst_perr",        64'(perr_a),        64'd0);
    check("rst_rd_count",    64'(rdc_a),         64'd0);
    check("rst_wr_count",    64'(wrc_a),         64'd0);
    check("rst_req_ready_b", 64'(req_ready_b),   64'd1);

    // Block 5: incrementing byte pattern, then read it back.
    for (int i = 0; i < BEATS; i++) wbuf[i] = 64'h0706050403020100 + 64'(i) * 64'h0808080808080808;
    do_write(5, 7, BEATS);
    do_read(5, -1, 0, acc1, lst1);
    check("blk5_beat0", got[0], 64'h0706050403020100);
    check("blk5_beat3", got[3], 64'h1f1e1d1c1b1a1918);
    check("blk5_beat7", got[7], 64'h3f3e3d3c3b3a3938);

    // Never-written block, consumer stalls 3 cycles on beat 2.
    do_read(16383, 2, 3, acc1, lst1);
    check("blk16383_beat2", got[2], 64'd0);

    // wdata_last on beat 3: flagged, still a full 8-beat transfer.
    for (int i = 0; i < BEATS; i++) wbuf[i] = 64'hdeadbeef00000000 | 64'(i);
    do_write(9, 3, BEATS);
    repeat (3) @(posedge clk);
    #1 check("perr_sticky", 64'(cur_perr), 64'd1);
    do_read(9, -1, 0, acc1, lst1);
    check("blk9_beat6", got[6], 64'hdeadbeef00000006);

    // Block 7: full write, then a write cut by reset after beat 4.
    for (int i = 0; i < BEATS; i++) wbuf[i] = 64'h1111111111111111 * 64'(i + 1);
    do_write(7, 7, BEATS);
    for (int i = 0; i < BEATS; i++) wbuf[i] = 64'ha5a5000000000000 | 64'(i);
    do_write(7, 7, 5);
    do_read(7, -1, 0, acc1, lst1);
    check("blk7_beat4", got[4], 64'ha5a5000000000004);
    check("blk7_beat5", got[5], 64'h6666666666666666);
    check("rd_count_after_rst", 64'(cur_rdc), 64'd1);

    // Zero-latency instance: back-to-back reads.
    sel = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < BEATS; i++) wbuf[i] = 64'h0123456789abcdef ^ 64'(i * 3);
    do_write(3, 7, BEATS);
    do_read(3, -1, 0, acc1, lst1);
    do_read(3, -1, 0, acc2, lst2);
    check("b2b_accept_gap", 64'(acc2 - lst1), 64'd1);
    check("b_blk3_beat1", got[1], 64'h0123456789abcdec);
    do_read(0, -1, 0, acc1, lst1);
    check("b_rd_count", 64'(rdc_b), 64'd3);

    repeat (2) @(posedge clk);
    #1 check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
